// File: rtl/mc_maindec.sv
// Multicycle main decoder: Moore FSM that sequences fetch, decode, memory,
// ALU, immediate, branch and jump micro-steps and drives the datapath
// strobes/selects. State-only outputs are registered alongside the state;
// the few strobes qualified by the memory handshake or by the opcode in
// DECODE are combined from registered terms, and every write strobe is
// forced low while reset is asserted.
module mc_maindec #(
    parameter int ALUOP_W      = 3,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               irwrite,
    output logic               iord,
    output logic               memwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic               branch,
    output logic               blt,
    output logic [2:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               done,
    output logic               illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LI    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLT   = 6'b011111;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_ADDIEX, S_LUIEX, S_LIEX, S_IMMWB,
        S_BEQ, S_BLT, S_JUMP, S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic        op_illegal_s;

    // Registered state-only outputs and their next values
    logic        pcwrite_q,  pcwrite_d;
    logic        iord_q,     iord_d;
    logic        memwrite_q, memwrite_d;
    logic        regwrite_q, regwrite_d;
    logic        regdst_q,   regdst_d;
    logic        memtoreg_q, memtoreg_d;
    logic        alusrca_q,  alusrca_d;
    logic        branch_q,   branch_d;
    logic        blt_q,      blt_d;
    logic [2:0]  alusrcb_q,  alusrcb_d;
    logic [1:0]  pcsrc_q,    pcsrc_d;
    logic [2:0]  aluop_q,    aluop_d;
    logic        done_q,     done_d;
    logic        fetch_q,    fetch_d;
    logic        decode_q,   decode_d;
    logic        trap_q,     trap_d;

    // Classify the opcode: anything outside the supported set is illegal
    always_comb begin
        op_illegal_s = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_LUI,
            OP_LI, OP_BEQ, OP_BLT, OP_J: op_illegal_s = 1'b0;
            default:                     op_illegal_s = 1'b1;
        endcase
    end

    // Next-state logic; memory wait loops hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_RTYPEEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_LUI:        state_d = S_LUIEX;
                    OP_LI:         state_d = S_LIEX;
                    OP_BEQ:        state_d = S_BEQ;
                    OP_BLT:        state_d = S_BLT;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_IMMWB;
            S_LUIEX:   state_d = S_IMMWB;
            S_LIEX:    state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_BLT:     state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode of the upcoming state so outputs register with the state
    always_comb begin
        pcwrite_d  = 1'b0;
        iord_d     = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        regdst_d   = 1'b0;
        memtoreg_d = 1'b0;
        alusrca_d  = 1'b0;
        branch_d   = 1'b0;
        blt_d      = 1'b0;
        alusrcb_d  = 3'b000;
        pcsrc_d    = 2'b00;
        aluop_d    = 3'b000;
        done_d     = 1'b0;
        fetch_d    = 1'b0;
        decode_d   = 1'b0;
        trap_d     = 1'b0;
        case (state_d)
            S_FETCH:   begin fetch_d = 1'b1; alusrcb_d = 3'b001; end
            S_DECODE:  begin decode_d = 1'b1; alusrcb_d = 3'b011; end
            S_MEMADR:  begin alusrca_d = 1'b1; alusrcb_d = 3'b010; end
            S_MEMRD:   iord_d = 1'b1;
            S_MEMWB:   begin memtoreg_d = 1'b1; regwrite_d = 1'b1; done_d = 1'b1; end
            S_MEMWR:   begin iord_d = 1'b1; memwrite_d = 1'b1; end
            S_RTYPEEX: begin alusrca_d = 1'b1; aluop_d = 3'b010; end
            S_ALUWB:   begin regdst_d = 1'b1; regwrite_d = 1'b1; done_d = 1'b1; end
            S_ADDIEX:  begin alusrca_d = 1'b1; alusrcb_d = 3'b010; end
            S_LUIEX:   begin alusrca_d = 1'b1; alusrcb_d = 3'b100; aluop_d = 3'b100; end
            S_LIEX:    begin alusrca_d = 1'b1; alusrcb_d = 3'b101; aluop_d = 3'b100; end
            S_IMMWB:   begin regwrite_d = 1'b1; done_d = 1'b1; end
            S_BEQ: begin
                alusrca_d = 1'b1; aluop_d = 3'b001; pcsrc_d = 2'b01;
                branch_d  = 1'b1; done_d  = 1'b1;
            end
            S_BLT: begin
                alusrca_d = 1'b1; aluop_d = 3'b011; pcsrc_d = 2'b01;
                blt_d     = 1'b1; done_d  = 1'b1;
            end
            S_JUMP:    begin pcsrc_d = 2'b10; pcwrite_d = 1'b1; done_d = 1'b1; end
            S_TRAP:    trap_d = 1'b1;
            default:   trap_d = 1'b0;
        endcase
    end

    // State and registered outputs; reset lands in FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pcwrite_q  <= 1'b0;
            iord_q     <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            regdst_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrca_q  <= 1'b0;
            branch_q   <= 1'b0;
            blt_q      <= 1'b0;
            alusrcb_q  <= 3'b001;
            pcsrc_q    <= 2'b00;
            aluop_q    <= 3'b000;
            done_q     <= 1'b0;
            fetch_q    <= 1'b1;
            decode_q   <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcwrite_q  <= pcwrite_d;
            iord_q     <= iord_d;
            memwrite_q <= memwrite_d;
            regwrite_q <= regwrite_d;
            regdst_q   <= regdst_d;
            memtoreg_q <= memtoreg_d;
            alusrca_q  <= alusrca_d;
            branch_q   <= branch_d;
            blt_q      <= blt_d;
            alusrcb_q  <= alusrcb_d;
            pcsrc_q    <= pcsrc_d;
            aluop_q    <= aluop_d;
            done_q     <= done_d;
            fetch_q    <= fetch_d;
            decode_q   <= decode_d;
            trap_q     <= trap_d;
        end
    end

    // Output assembly: handshake-qualified strobes, zero-extended aluop, reset gating
    always_comb begin
        aluop      = '0;
        aluop[2:0] = aluop_q;
        pcwrite    = ~reset & (pcwrite_q | (fetch_q & mem_ready));
        irwrite    = ~reset & fetch_q & mem_ready;
        memwrite   = ~reset & memwrite_q;
        regwrite   = ~reset & regwrite_q;
        done       = ~reset & (done_q | (memwrite_q & mem_ready));
        illegal    = ~reset & (trap_q |
                     (decode_q & op_illegal_s & (ILLEGAL_TRAP == 1'b0)));
        iord       = iord_q;
        regdst     = regdst_q;
        memtoreg   = memtoreg_q;
        alusrca    = alusrca_q;
        branch     = branch_q;
        blt        = blt_q;
        alusrcb    = alusrcb_q;
        pcsrc      = pcsrc_q;
    end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter ALUOP_W, default 3: aluop width; SHALL be >= 3; 3-bit codes zero-extended.
REQ-002 Parameter ILLEGAL_TRAP, default 1: 1 = illegal opcode parks in TRAP; 0 = illegal opcode returns to FETCH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op  input  6  opcode from instruction register, sampled in DECODE.
REQ-006 mem_ready  input  1  memory handshake; 1 = current access completes this cycle.
REQ-007 pcwrite, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, branch, blt  output  1 each  datapath strobes/selects.
REQ-008 alusrcb  output  3  000 regB, 001 const 4, 010 signext imm, 011 signext imm<<2, 100 imm<<16 (lui), 101 zeroext imm (li).
REQ-009 pcsrc  output  2  00 ALU result, 01 ALUOut (branch), 10 jump target.
REQ-010 aluop  output  ALUOP_W  000 add, 001 sub, 010 funct, 011 slt-compare, 100 pass-B.
REQ-011 done  output  1  high during final cycle of each instruction.
REQ-012 illegal  output  1  high while in TRAP, or for one DECODE cycle when ILLEGAL_TRAP=0.

Function
REQ-013 Block SHALL be a Moore FSM; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, ADDIEX, LUIEX, LIEX, IMMWB, BEQ, BLT, JUMP, TRAP.
REQ-014 Any output not listed for a state SHALL be 0 (never x).
REQ-015 FETCH: alusrcb=001, aluop=000, pcsrc=00, iord=0; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-016 DECODE: alusrcb=011, aluop=000; next by op: 000000 RTYPEEX, 100011/101011 MEMADR, 001000 ADDIEX, 001111 LUIEX, 010001 LIEX, 000100 BEQ, 011111 BLT, 000010 JUMP, else illegal.
REQ-017 MEMADR: alusrca=1, alusrcb=010, aluop=000; next MEMRD if op=100011, MEMWR if op=101011 (op held stable by IR).
REQ-018 MEMRD: iord=1; stay while mem_ready=0, else MEMWB.
REQ-019 MEMWB: memtoreg=1, regwrite=1, done=1; next FETCH.
REQ-020 MEMWR: iord=1, memwrite=1; stay while mem_ready=0; done=mem_ready; next FETCH when mem_ready=1.
REQ-021 RTYPEEX: alusrca=1, alusrcb=000, aluop=010; next ALUWB.
REQ-022 ALUWB: regdst=1, regwrite=1, done=1; next FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=010, aluop=000; LUIEX: alusrca=1, alusrcb=100, aluop=100; LIEX: alusrca=1, alusrcb=101, aluop=100; all next IMMWB.
REQ-024 IMMWB: regdst=0, memtoreg=0, regwrite=1, done=1; next FETCH.
REQ-025 BEQ: alusrca=1, alusrcb=000, aluop=001, pcsrc=01, branch=1, done=1; next FETCH.
REQ-026 BLT: alusrca=1, alusrcb=000, aluop=011, pcsrc=01, blt=1, done=1; next FETCH.
REQ-027 JUMP: pcsrc=10, pcwrite=1, done=1; next FETCH.
REQ-028 Illegal op: ILLEGAL_TRAP=1 -> TRAP (illegal=1, all strobes 0, held until reset); ILLEGAL_TRAP=0 -> illegal=1 in DECODE, next FETCH, no done.
REQ-029 Zero-wait latency (FETCH..done): LW 5, SW 4, R/ADDI/LUI/LI 4, BEQ/BLT/J 3 cycles; each mem_ready=0 cycle adds one.
REQ-030 mem_ready SHALL be ignored in states without a memory access.

Reset
REQ-031 reset=1 SHALL force state FETCH immediately (asynchronously), independent of clk.
REQ-032 While reset=1: pcwrite, irwrite, memwrite, regwrite, done, illegal SHALL be 0.
REQ-033 Reset mid-instruction (any state incl. TRAP, wait loops) SHALL abandon it; first cycle after release is FETCH with no write strobe from the abandoned instruction.

Verification
REQ-034 reset release, op=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1, done=1 in cycle 5.
REQ-035 op=101011, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, done only in 4th, then FETCH.
REQ-036 op=011111 -> cycle 3: blt=1, aluop=011, pcsrc=01, branch=0, done=1; op=000100 -> branch=1, aluop=001.
REQ-037 op=001111 then op=010001 -> alusrcb 100 then 101, aluop=100, IMMWB regwrite=1, regdst=0.
REQ-038 op=111111, ILLEGAL_TRAP=1 -> TRAP, illegal=1 held 10 cycles, no pcwrite; assert reset -> FETCH. ILLEGAL_TRAP=0 -> illegal pulse 1 cycle, then FETCH.
REQ-039 mem_ready=0 in FETCH 5 cycles -> irwrite=pcwrite=0 throughout; reset asserted mid-LW at MEMRD -> outputs 0 immediately, FETCH after release.
